// File: rtl/mio_bus_responder.sv
// Slave-side responder for the multi-cycle CPU's MIO handshake.
// It decodes requests onto block RAM or peripheral registers and answers each one with a one-cycle mio_ready pulse.
module mio_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RAM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [31:0]       sw_in,
    output logic [31:0]       led_out,
    output logic              bus_err
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_LED,
        RG_SW,
        RG_CNT,
        RG_NONE
    } region_e;

    state_e            state_q, state_d;
    region_e           region_q, region_d, region_dec;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_din_q, ram_din_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       led_q, led_d;
    logic [31:0]       tick_q, tick_d;
    logic              bus_err_q, bus_err_d;

    logic req;
    logic wr_dec;
    logic err_dec;

    assign req     = cpu_mio & (mem_r | mem_w);
    // Simultaneous read and write is served as a read; the write is dropped.
    assign wr_dec  = mem_w & ~mem_r;
    assign err_dec = (region_dec == RG_NONE) | (mem_r & mem_w);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        region_dec = RG_NONE;
        if (addr[31] == 1'b0) begin
            region_dec = RG_RAM;
        end else if (addr[31:28] == 4'hE) begin
            region_dec = RG_LED;
        end else if (addr[31:28] == 4'hF) begin
            region_dec = addr[2] ? RG_CNT : RG_SW;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (region_dec == RG_RAM) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        mio_ready = (state_q == ST_DONE);
        ram_we    = (state_q == ST_DONE) && wr_q && (region_q == RG_RAM);
    end

    // Datapath next-state logic.
    always_comb begin
        region_d   = region_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rdata_d    = rdata_q;
        led_d      = led_q;
        bus_err_d  = bus_err_q;
        tick_d     = tick_q + 32'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    region_d   = region_dec;
                    wr_d       = wr_dec;
                    ram_addr_d = addr[RAM_AW+1:2];
                    ram_din_d  = wdata;
                    cnt_d      = CW'(WAIT_CYCLES - 1);
                    if (err_dec) begin
                        bus_err_d = 1'b1;
                    end
                    if (!wr_dec) begin
                        // RAM reads load rdata later, from the BUSY state.
                        unique case (region_dec)
                            RG_LED:  rdata_d = led_q;
                            RG_SW:   rdata_d = sw_in;
                            RG_CNT:  rdata_d = tick_q;
                            RG_NONE: rdata_d = 32'd0;
                            default: rdata_d = rdata_q;
                        endcase
                    end else if (region_dec == RG_LED) begin
                        led_d = wdata;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        rdata_d = ram_dout;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            region_q   <= RG_NONE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= 32'd0;
            rdata_q    <= 32'd0;
            led_q      <= 32'd0;
            tick_q     <= 32'd0;
            bus_err_q  <= 1'b0;
        end else begin
            region_q   <= region_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rdata_q    <= rdata_d;
            led_q      <= led_d;
            tick_q     <= tick_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign rdata    = rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign led_out  = led_q;
    assign bus_err  = bus_err_q;

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder on the slave side of the multi-cycle CPU's MIO handshake. It accepts the controller's read/write requests (MemRead, MemWrite, CPU_MIO, address, write data), decodes the address into block RAM or on-chip peripheral registers, and inserts wait states. It returns read data together with a one-cycle `mio_ready` completion pulse, which the controller samples to leave its wait states.

## Interface
- `WAIT_CYCLES`, default 1: RAM access wait states, at least 1 (synchronous RAM output latency).
- `RAM_AW`, default 10: RAM word-address width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cpu_mio`  in  1  CPU owns the bus; requests are ignored while it is 0.
- `mem_r`  in  1  read request, held until `mio_ready`.
- `mem_w`  in  1  write request, held until `mio_ready`.
- `addr`  in  32  byte address, word aligned; `addr[1:0]` is ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `mio_ready`  out  1  one-cycle completion pulse.
- `ram_addr`  out  RAM_AW  RAM word address, latched.
- `ram_din`  out  32  RAM write data, latched.
- `ram_we`  out  1  RAM write enable, one cycle wide.
- `ram_dout`  in  32  RAM read data.
- `sw_in`  in  32  switch inputs.
- `led_out`  out  32  LED register.
- `bus_err`  out  1  sticky error flag.

## Operation
- A request is `cpu_mio & (mem_r | mem_w)`. It is sampled only in IDLE.
- Address map, decoded on `addr[31:28]`:
  - 0x0–0x7: RAM, word index `addr[RAM_AW+1:2]`.
  - 0xE: LED register, read/write.
  - 0xF with `addr[2]`=0: `sw_in`, read-only.
  - 0xF with `addr[2]`=1: free-running 32-bit cycle counter, read-only. It wraps 0xFFFFFFFF→0.
  - Any other region: unmapped.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, request present: latch addr, wdata, op and region. A RAM request goes to BUSY with `cnt=WAIT_CYCLES-1`. Every other request goes directly to DONE.
  - BUSY: if `cnt==0`, capture `ram_dout` into `rdata` (reads) and go to DONE. Otherwise decrement `cnt`.
  - DONE: `mio_ready`=1 for exactly this cycle. For a RAM write, `ram_we`=1 in this cycle. On the next edge go to IDLE; there is no request acceptance on this edge.
- Peripheral reads: `rdata` is loaded on the IDLE→DONE edge with the LED, switch or counter value. For the counter, this is the value at that edge.
- LED write: `led_out` <= `wdata` on the IDLE→DONE edge.
- Writes to 0xF are ignored, but the access still completes.
- `rdata` holds its value until the next completed read; writes do not change it.
- Error conditions complete normally (`mio_ready` pulse) and set `bus_err`:
  - unmapped access: `rdata` loads 0, nothing is written.
  - `mem_r` and `mem_w` both high: treated as a read, no write.
- `bus_err` clears only on reset.
- Request inputs are not re-sampled in BUSY or DONE. Dropping the request mid-access does not abort the access.

## Timing
- Reset values: state IDLE, `mio_ready`=0, `ram_we`=0, `rdata`=0, `led_out`=0, `bus_err`=0, counter=0, `ram_addr`=0, `ram_din`=0.
- Reset mid-access: the access is abandoned. No `mio_ready` and no `ram_we` follow it.
- RAM access latency: request sampled at edge E; `mio_ready` is high in the cycle after edge E+WAIT_CYCLES (default: 2 cycles after the request appears).
- Peripheral or error access latency: `mio_ready` is high in the cycle after edge E.
- Back-to-back requests: a request held through DONE is accepted at the edge after DONE. Minimum spacing is one IDLE turnaround cycle.
- `rdata` is valid in the same cycle as `mio_ready`.

## Test plan
- Reset/idle: assert `rst` 2 cycles, with `cpu_mio`=0 and `mem_r`=1. Required: outputs at reset values, and `mio_ready` stays 0 for 10 cycles.
- RAM write then read: with WAIT_CYCLES=1, write 0x12345678 to 0x00000010.
  - `ram_we`=1 for one cycle with `ram_addr`=4 and `ram_din`=0x12345678.
  - The read (model returns the stored word) gives `rdata`=0x12345678 during a 1-cycle `mio_ready`, 2 cycles after the request.
- LED/switch/counter:
  - Write 0xA5 to 0xE0000000: `led_out`=0xA5, ready 1 cycle after the request.
  - Read 0xE0000000: returns 0xA5.
  - Read 0xF0000000 with `sw_in`=0xBEEF: returns 0xBEEF.
  - Two reads of 0xF0000004 issued N cycles apart: returned values differ by N.
  - Write to 0xF0000004: ignored.
- Errors:
  - Read 0x90000000: `rdata`=0, `mio_ready` pulse, `bus_err`=1.
  - `mem_r`=`mem_w`=1 to RAM: no `ram_we`, `bus_err`=1.
  - `bus_err` remains 1 until `rst`.
- Hold/back-to-back: hold `mem_r` continuously with WAIT_CYCLES=3. Required: `mio_ready` pulses exactly every 5 cycles, never 2 consecutive cycles.
- Reset mid-access: with WAIT_CYCLES=3, assert `rst` in the first BUSY cycle of a write. Required: no `ram_we`, no `mio_ready`, state returns to IDLE.
